// File: rtl/ioctl_host.sv
// ioctl_host: drives a MiSTer-style ioctl bus from a simple command port, streaming
// words from a valid/ready source (download) or into a valid/ready sink (upload).
module ioctl_host #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic                  cmd_start,
  input  logic                  cmd_upload,
  input  logic [7:0]            cmd_index,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_length,
  output logic                  cmd_busy,
  output logic                  cmd_done,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  snk_valid,
  input  logic                  snk_ready,
  output logic [DATA_WIDTH-1:0] snk_data,
  output logic                  ioctl_download,
  output logic                  ioctl_upload,
  output logic                  ioctl_wr,
  output logic                  ioctl_rd,
  output logic [7:0]            ioctl_index,
  output logic [ADDR_WIDTH-1:0] ioctl_addr,
  output logic [DATA_WIDTH-1:0] ioctl_dout,
  input  logic [DATA_WIDTH-1:0] ioctl_din,
  input  logic                  ioctl_wait
);

  typedef enum logic [2:0] {
    IDLE, DL_FETCH, DL_STROBE, DL_GAP, UL_STROBE, UL_WAIT, UL_PUSH, FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] remaining;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state          <= IDLE;
      remaining      <= '0;
      cmd_busy       <= 1'b0;
      cmd_done       <= 1'b0;
      src_ready      <= 1'b0;
      snk_valid      <= 1'b0;
      snk_data       <= '0;
      ioctl_download <= 1'b0;
      ioctl_upload   <= 1'b0;
      ioctl_wr       <= 1'b0;
      ioctl_rd       <= 1'b0;
      ioctl_index    <= '0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_done <= 1'b0;
          if (cmd_start) begin
            ioctl_index <= cmd_index;
            ioctl_addr  <= {cmd_base[ADDR_WIDTH-1:1], 1'b0};
            remaining   <= cmd_length;
            cmd_busy    <= 1'b1;
            // Zero-length commands complete without ever raising a direction flag.
            if (cmd_length == '0) begin
              state <= FINISH;
            end else if (cmd_upload) begin
              ioctl_upload <= 1'b1;
              state        <= UL_STROBE;
            end else begin
              ioctl_download <= 1'b1;
              src_ready      <= 1'b1;
              state          <= DL_FETCH;
            end
          end
        end

        DL_FETCH: begin
          if (src_valid && src_ready) begin
            ioctl_dout <= src_data;
            src_ready  <= 1'b0;
            state      <= DL_STROBE;
          end
        end

        DL_STROBE: begin
          if (!ioctl_wait) begin
            ioctl_wr <= 1'b1;
            state    <= DL_GAP;
          end
        end

        DL_GAP: begin
          ioctl_wr   <= 1'b0;
          ioctl_addr <= ioctl_addr + ADDR_STEP;
          remaining  <= remaining - ONE;
          if (remaining == ONE) begin
            state <= FINISH;
          end else begin
            src_ready <= 1'b1;
            state     <= DL_FETCH;
          end
        end

        UL_STROBE: begin
          if (!ioctl_wait) begin
            ioctl_rd <= 1'b1;
            state    <= UL_WAIT;
          end
        end

        // ioctl_rd is still high on the first edge here, which gives the core
        // its mandatory extra cycle before ioctl_din is sampled.
        UL_WAIT: begin
          ioctl_rd <= 1'b0;
          if (!ioctl_rd && !ioctl_wait) begin
            snk_data  <= ioctl_din;
            snk_valid <= 1'b1;
            state     <= UL_PUSH;
          end
        end

        UL_PUSH: begin
          if (snk_ready) begin
            snk_valid  <= 1'b0;
            ioctl_addr <= ioctl_addr + ADDR_STEP;
            remaining  <= remaining - ONE;
            state      <= (remaining == ONE) ? FINISH : UL_STROBE;
          end
        end

        FINISH: begin
          ioctl_download <= 1'b0;
          ioctl_upload   <= 1'b0;
          cmd_busy       <= 1'b0;
          cmd_done       <= 1'b1;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_host.sv
// Bench for ioctl_host: directed vector table, reset sequences and randomized
// transfers checked against a transfer-level model of the ioctl stream.
module tb_ioctl_host;
  localparam int AW = 27;
  localparam int DW = 16;

  logic          clk_sys = 1'b0;
  logic          rst_sys;
  logic          cmd_start, cmd_upload;
  logic [7:0]    cmd_index;
  logic [AW-1:0] cmd_base, cmd_length;
  logic          cmd_busy, cmd_done;
  logic          src_valid, src_ready;
  logic [DW-1:0] src_data;
  logic          snk_valid, snk_ready;
  logic [DW-1:0] snk_data;
  logic          ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd;
  logic [7:0]    ioctl_index;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout, ioctl_din;
  logic          ioctl_wait;

  always #5 clk_sys = ~clk_sys;

  ioctl_host #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .cmd_start(cmd_start), .cmd_upload(cmd_upload), .cmd_index(cmd_index),
    .cmd_base(cmd_base), .cmd_length(cmd_length),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait)
  );

  typedef struct {
    bit            up;
    logic [7:0]    index;
    logic [AW-1:0] base;
    logic [AW-1:0] length;
    int            wait_mode;
    int            src_mode;
    int            snk_mode;
    bit            busy_start;
    int            exp_done;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    int            exp_gap;
  } vec_t;

  int tests = 0;
  int failed = 0;

  logic [DW-1:0] src_words[$];
  logic [DW-1:0] core_words[$];
  logic [AW-1:0] wr_addr[$];
  logic [AW-1:0] rd_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [DW-1:0] snk_words[$];
  int            strobe_stamp[$];
  int            done_stamp, done_cnt, viol, state_err, idle_err;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] ctrlBits();
    return {cmd_busy, cmd_done, src_ready, snk_valid, ioctl_download, ioctl_upload, ioctl_wr, ioctl_rd};
  endfunction

  // Word i of a transfer lives at the even-aligned base plus 2*i, wrapping at 2^AW.
  function automatic logic [AW-1:0] modelAddr(input logic [AW-1:0] base, input int i);
    longint unsigned span = 64'd1 << AW;
    longint unsigned a = (longint'(base) / 2) * 2 + 2 * longint'(i);
    return AW'(a % span);
  endfunction

  function automatic logic [DW-1:0] coreWord(input int i);
    return (i < core_words.size()) ? core_words[i] : '0;
  endfunction

  // Issues one command, plays source/sink/core for it cycle by cycle, then
  // compares the observed stream with the model.
  task automatic applyStimulus(input bit up, input logic [7:0] idx, input logic [AW-1:0] base,
                               input logic [AW-1:0] len, input int wmode, input int smode,
                               input int kmode, input bit busy_start);
    int src_i = 0, core_i = 0, hold = 0, stall_first = 0;
    int budget = 100 + 60 * int'(len);
    int exp_n;
    bit held = 0, prev_wr = 0, prev_rd = 0, prev_wait = 0, stalled = 0, prev_snk_valid = 0;
    logic [DW-1:0] stall_data = '0;
    logic [1:0] flag_exp = (len == 0) ? 2'b00 : (up ? 2'b01 : 2'b10);
    wr_addr.delete(); rd_addr.delete(); wr_data.delete(); snk_words.delete(); strobe_stamp.delete();
    done_cnt = 0; done_stamp = -1; viol = 0; state_err = 0; idle_err = 0;
    exp_n = int'(len);

    @(negedge clk_sys);
    ioctl_wait = 1'b0; src_valid = 1'b0; snk_ready = 1'b1;
    cmd_upload = up; cmd_index = idx; cmd_base = base; cmd_length = len; cmd_start = 1'b1;
    @(negedge clk_sys);
    cmd_start = 1'b0;

    for (int s = 0; s < budget && done_cnt == 0; s++) begin
      if (cmd_done) begin done_cnt++; done_stamp = s; end
      if ({cmd_busy, ioctl_download, ioctl_upload} != (cmd_done ? 3'b000 : {1'b1, flag_exp})) state_err++;
      if ((ioctl_wr || ioctl_rd) && ioctl_index != idx) state_err++;
      if ((prev_wr && ioctl_wr) || (prev_rd && ioctl_rd)) viol++;
      if (prev_wait && (ioctl_wr || ioctl_rd || (snk_valid && !prev_snk_valid))) viol++;
      if (stalled && (!snk_valid || snk_data != stall_data)) viol++;
      if (src_ready && !ioctl_download) viol++;
      if (ioctl_wr) begin wr_addr.push_back(ioctl_addr); wr_data.push_back(ioctl_dout); strobe_stamp.push_back(s); end
      if (ioctl_rd) begin rd_addr.push_back(ioctl_addr); strobe_stamp.push_back(s); end

      // Core: garbage on the read cycle, the real word from the next cycle on.
      if (ioctl_rd) ioctl_din = ~coreWord(core_i);
      else if (prev_rd) begin ioctl_din = coreWord(core_i); core_i++; end
      prev_wr = ioctl_wr; prev_rd = ioctl_rd; prev_snk_valid = snk_valid;

      if (busy_start && s == 0) begin
        cmd_upload = !up; cmd_length = AW'(5); cmd_base = base + AW'(64); cmd_start = 1'b1;
      end else cmd_start = 1'b0;

      if (wmode == 2 && ioctl_wr && !held) begin hold = 5; held = 1; end
      if (wmode == 1) ioctl_wait = ($urandom_range(0, 99) < 35);
      else ioctl_wait = (hold > 0);
      if (hold > 0) hold--;
      prev_wait = ioctl_wait;

      src_valid = (smode == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
      src_data = (src_valid && src_i < src_words.size()) ? src_words[src_i] : DW'($urandom);
      if (src_ready && src_valid) src_i++;

      case (kmode)
        0: snk_ready = 1'b1;
        1: snk_ready = ($urandom_range(0, 99) < 50);
        default: snk_ready = !(snk_valid && snk_words.size() == 0 && stall_first < 3);
      endcase
      if (snk_valid && !snk_ready && snk_words.size() == 0) stall_first++;
      stalled = snk_valid && !snk_ready;
      stall_data = snk_data;
      if (snk_valid && snk_ready) snk_words.push_back(snk_data);
      @(negedge clk_sys);
    end

    cmd_start = 1'b0; src_valid = 1'b0; ioctl_wait = 1'b0; snk_ready = 1'b1;
    repeat (4) begin
      if (ctrlBits() != 8'd0) idle_err++;
      @(negedge clk_sys);
    end

    checkOutput("done_pulses", 64'(done_cnt), 64'd1);
    checkOutput("write_count", 64'(wr_addr.size()), 64'(up ? 0 : exp_n));
    checkOutput("read_count", 64'(rd_addr.size()), 64'(up ? exp_n : 0));
    checkOutput("sink_count", 64'(snk_words.size()), 64'(up ? exp_n : 0));
    for (int i = 0; i < wr_addr.size() && i < exp_n; i++) begin
      checkOutput("write_addr", 64'(wr_addr[i]), 64'(modelAddr(base, i)));
      checkOutput("write_data", 64'(wr_data[i]), 64'(src_words[i]));
    end
    for (int i = 0; i < rd_addr.size() && i < exp_n; i++)
      checkOutput("read_addr", 64'(rd_addr[i]), 64'(modelAddr(base, i)));
    for (int i = 0; i < snk_words.size() && i < exp_n; i++)
      checkOutput("sink_data", 64'(snk_words[i]), 64'(core_words[i]));
    checkOutput("protocol", 64'(viol), 64'd0);
    checkOutput("flags_busy", 64'(state_err), 64'd0);
    checkOutput("idle_after_done", 64'(idle_err), 64'd0);
  endtask

  task automatic runVector(input vec_t v);
    logic [AW-1:0] seen[$];
    src_words = '{16'h00A1, 16'h00B2, 16'h00C3};
    core_words = '{16'h1234, 16'h5678};
    repeat (6) begin src_words.push_back(DW'($urandom)); core_words.push_back(DW'($urandom)); end
    applyStimulus(v.up, v.index, v.base, v.length, v.wait_mode, v.src_mode, v.snk_mode, v.busy_start);
    checkOutput("done_cycle", 64'(done_stamp), 64'(v.exp_done));
    if (v.up) seen = rd_addr; else seen = wr_addr;
    if (v.length != 0) begin
      checkOutput("first_addr", 64'(seen.size() > 0 ? seen[0] : {AW{1'b1}}), 64'(v.exp_first));
      checkOutput("last_addr", 64'(seen.size() > 0 ? seen[$] : {AW{1'b1}}), 64'(v.exp_last));
    end
    if (v.exp_gap >= 0)
      checkOutput("strobe_gap", 64'(strobe_stamp.size() >= 2 ? strobe_stamp[1] - strobe_stamp[0] : -1),
                  64'(v.exp_gap));
  endtask

  initial begin
    vec_t vecs[7];
    logic [AW-1:0] r_base, r_len;
    bit r_up;
    int abort_err;

    vecs[0] = '{up: 1'b0, index: 8'h00, base: 27'h100, length: 27'd3, wait_mode: 0, src_mode: 0, snk_mode: 0,
                busy_start: 1'b0, exp_done: 10, exp_first: 27'h100, exp_last: 27'h104, exp_gap: 3};
    vecs[1] = '{up: 1'b0, index: 8'h05, base: 27'h100, length: 27'd3, wait_mode: 2, src_mode: 0, snk_mode: 0,
                busy_start: 1'b0, exp_done: 13, exp_first: 27'h100, exp_last: 27'h104, exp_gap: 6};
    vecs[2] = '{up: 1'b1, index: 8'h02, base: 27'h0, length: 27'd2, wait_mode: 0, src_mode: 0, snk_mode: 2,
                busy_start: 1'b0, exp_done: 12, exp_first: 27'h0, exp_last: 27'h2, exp_gap: 7};
    vecs[3] = '{up: 1'b0, index: 8'h09, base: 27'h40, length: 27'd0, wait_mode: 0, src_mode: 0, snk_mode: 0,
                busy_start: 1'b1, exp_done: 1, exp_first: 27'h0, exp_last: 27'h0, exp_gap: -1};
    vecs[4] = '{up: 1'b0, index: 8'h11, base: 27'h7FFFFFE, length: 27'd2, wait_mode: 0, src_mode: 0, snk_mode: 0,
                busy_start: 1'b0, exp_done: 7, exp_first: 27'h7FFFFFE, exp_last: 27'h0, exp_gap: 3};
    vecs[5] = '{up: 1'b1, index: 8'hFF, base: 27'h201, length: 27'd1, wait_mode: 0, src_mode: 0, snk_mode: 0,
                busy_start: 1'b0, exp_done: 5, exp_first: 27'h200, exp_last: 27'h200, exp_gap: -1};
    vecs[6] = '{up: 1'b1, index: 8'h33, base: 27'h80, length: 27'd0, wait_mode: 0, src_mode: 0, snk_mode: 0,
                busy_start: 1'b1, exp_done: 1, exp_first: 27'h0, exp_last: 27'h0, exp_gap: -1};

    rst_sys = 1'b1; cmd_start = 1'b0; cmd_upload = 1'b0; cmd_index = '0; cmd_base = '0; cmd_length = '0;
    src_valid = 1'b0; src_data = '0; snk_ready = 1'b0; ioctl_din = '0; ioctl_wait = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_ctrl", 64'(ctrlBits()), 64'd0);
    checkOutput("reset_addr", 64'(ioctl_addr), 64'd0);
    checkOutput("reset_data", 64'({ioctl_index, ioctl_dout, snk_data}), 64'd0);
    rst_sys = 1'b0;
    @(negedge clk_sys);
    checkOutput("idle_after_reset", 64'(ctrlBits()), 64'd0);

    for (int i = 0; i < 7; i++) runVector(vecs[i]);

    // Reset while a download sits in DL_STROBE held off by ioctl_wait.
    cmd_upload = 1'b0; cmd_index = 8'h5A; cmd_base = 27'h300; cmd_length = 27'd4; cmd_start = 1'b1;
    src_valid = 1'b1; src_data = 16'hBEEF; ioctl_wait = 1'b1;
    @(negedge clk_sys);
    cmd_start = 1'b0;
    @(negedge clk_sys);
    checkOutput("dout_before_reset", 64'(ioctl_dout), 64'hBEEF);
    checkOutput("addr_before_reset", 64'(ioctl_addr), 64'h300);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    checkOutput("abort_ctrl", 64'(ctrlBits()), 64'd0);
    checkOutput("abort_addr", 64'(ioctl_addr), 64'd0);
    checkOutput("abort_data", 64'({ioctl_index, ioctl_dout, snk_data}), 64'd0);
    rst_sys = 1'b0; ioctl_wait = 1'b0; src_valid = 1'b0;
    abort_err = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (ctrlBits() != 8'd0) abort_err++;
    end
    checkOutput("abort_quiet", 64'(abort_err), 64'd0);
    runVector(vecs[0]);

    for (int t = 0; t < 12; t++) begin
      r_up = 1'($urandom_range(0, 1));
      r_base = (t % 3 == 0) ? AW'(27'h7FFFFF8) + AW'($urandom_range(0, 7)) : AW'($urandom);
      r_len = AW'($urandom_range(0, 6));
      src_words.delete(); core_words.delete();
      repeat (8) begin src_words.push_back(DW'($urandom)); core_words.push_back(DW'($urandom)); end
      applyStimulus(r_up, 8'($urandom), r_base, r_len, 1, 1, 1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
